// File: rtl/jesd_link_pkg.sv
// rtl/jesd_link_pkg.sv - JESD204B link controller encodings and K-characters
package jesd_link_pkg;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_t;

  localparam logic [1:0] LANE_CGS  = 2'd0;
  localparam logic [1:0] LANE_ILAS = 2'd1;
  localparam logic [1:0] LANE_DATA = 2'd2;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

endpackage

// File: rtl/jesd_ilas_gen.sv
// rtl/jesd_ilas_gen.sv - ILAS control octet and K-flag generation for one frame
module jesd_ilas_gen
  import jesd_link_pkg::*;
#(
  parameter int F  = 2,
  parameter int K  = 16,
  parameter int CW = 4,
  parameter int MW = 2
) (
  input  logic [MW-1:0]  mf,
  input  logic [CW-1:0]  lmfc_cnt,
  input  logic [111:0]   cfg_data,
  output logic [F*8-1:0] octets,
  output logic [F-1:0]   k
);

  localparam logic [7:0] LAST_IDX = 8'(F*K-1);

  // Returns {k_flag, octet} for multiframe octet index i.
  function automatic logic [8:0] ilas_octet(input logic [7:0] i, input logic mf_one,
                                            input logic [111:0] cfg);
    logic [6:0]   off;
    logic [111:0] sh;
    off = {i[3:0] - 4'd2, 3'b000};
    sh  = cfg >> off;
    if (i == 8'd0)
      return {1'b1, K28_0};
    else if (i == LAST_IDX)
      return {1'b1, K28_3};
    else if (mf_one && i == 8'd1)
      return {1'b1, K28_4};
    else if (mf_one && i >= 8'd2 && i <= 8'd15)
      return {1'b0, sh[7:0]};
    else
      return {1'b0, i};
  endfunction

  logic mf_one;
  assign mf_one = (mf == MW'(1));

  for (genvar j = 0; j < F; j++) begin : g_oct
    logic [7:0] idx;
    logic [8:0] res;
    assign idx = 8'(lmfc_cnt) * 8'(F) + 8'(j);
    assign res = ilas_octet(idx, mf_one, cfg_data);
    assign octets[8*j +: 8] = res[7:0];
    assign k[j] = res[8];
  end

endmodule

// File: rtl/jesd_link_ctrl.sv
// rtl/jesd_link_ctrl.sv - JESD204B transmit link controller: CGS, ILAS and DATA sequencing
module jesd_link_ctrl
  import jesd_link_pkg::*;
#(
  parameter int F        = 2,
  parameter int K        = 16,
  parameter int ILAS_MF  = 4,
  parameter int SYNC_ERR = 4,
  localparam int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           sync_n,
  input  logic [111:0]   cfg_data,
  output logic [1:0]     lane_sel,
  output logic [F*8-1:0] ctrl_octets,
  output logic [F-1:0]   ctrl_k,
  output logic [CW-1:0]  lmfc_cnt,
  output logic           lmfc_tick,
  output logic           tx_ready,
  output logic           link_up,
  output logic [7:0]     resync_cnt
);

  localparam int MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int EW = $clog2(SYNC_ERR + 1);

  link_state_t   state;
  logic          sync_q;
  logic [MW-1:0] mf;
  logic [EW-1:0] err_cnt;
  logic          lmfc_last;
  logic          mf_last;

  assign lmfc_last = (lmfc_cnt == CW'(K-1));
  assign mf_last   = (mf == MW'(ILAS_MF-1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_CGS;
      sync_q     <= 1'b0;
      lmfc_cnt   <= '0;
      mf         <= '0;
      err_cnt    <= '0;
      resync_cnt <= 8'd0;
    end else begin
      sync_q   <= sync_n;
      lmfc_cnt <= lmfc_last ? '0 : lmfc_cnt + CW'(1);
      unique case (state)
        ST_CGS: begin
          err_cnt <= '0;
          // Enter ILAS on a multiframe boundary so ILAS frame 0 lines up with LMFC 0.
          if (lmfc_last && sync_q) begin
            state <= ST_ILAS;
            mf    <= '0;
          end
        end
        ST_ILAS: begin
          err_cnt <= '0;
          if (!sync_q) begin
            state <= ST_CGS;
            mf    <= '0;
          end else if (lmfc_last) begin
            if (mf_last) begin
              state <= ST_DATA;
              mf    <= '0;
            end else begin
              mf <= mf + MW'(1);
            end
          end
        end
        ST_DATA: begin
          if (sync_q) begin
            err_cnt <= '0;
          end else if (err_cnt == EW'(SYNC_ERR-1)) begin
            state   <= ST_CGS;
            err_cnt <= '0;
            if (resync_cnt != 8'hFF) resync_cnt <= resync_cnt + 8'd1;
          end else begin
            err_cnt <= err_cnt + EW'(1);
          end
        end
        default: begin
          state   <= ST_CGS;
          mf      <= '0;
          err_cnt <= '0;
        end
      endcase
    end
  end

  logic [F*8-1:0] ilas_octets;
  logic [F-1:0]   ilas_k;

  jesd_ilas_gen #(
    .F  (F),
    .K  (K),
    .CW (CW),
    .MW (MW)
  ) u_ilas_gen (
    .mf       (mf),
    .lmfc_cnt (lmfc_cnt),
    .cfg_data (cfg_data),
    .octets   (ilas_octets),
    .k        (ilas_k)
  );

  assign lmfc_tick = (lmfc_cnt == '0);

  always_comb begin
    lane_sel    = LANE_CGS;
    ctrl_octets = {F{K28_5}};
    ctrl_k      = '1;
    tx_ready    = 1'b0;
    link_up     = 1'b0;
    unique case (state)
      ST_ILAS: begin
        lane_sel    = LANE_ILAS;
        ctrl_octets = ilas_octets;
        ctrl_k      = ilas_k;
        // Raised one frame early so transport samples are valid on the first DATA frame.
        tx_ready    = mf_last && lmfc_last;
      end
      ST_DATA: begin
        lane_sel    = LANE_DATA;
        ctrl_octets = '0;
        ctrl_k      = '0;
        tx_ready    = 1'b1;
        link_up     = 1'b1;
      end
      default: begin
        lane_sel = LANE_CGS;
      end
    endcase
  end

endmodule

// File: tb/tb_jesd_link_ctrl.sv
// tb/tb_jesd_link_ctrl.sv - directed self-checking bench for jesd_link_ctrl
module tb_jesd_link_ctrl;

  logic         clock;
  logic         reset;
  logic         sync_n;
  logic [111:0] cfg_data;
  logic [1:0]   lane_sel;
  logic [15:0]  ctrl_octets;
  logic [1:0]   ctrl_k;
  logic [3:0]   lmfc_cnt;
  logic         lmfc_tick;
  logic         tx_ready;
  logic         link_up;
  logic [7:0]   resync_cnt;

  int checks = 0;
  int errors = 0;

  jesd_link_ctrl #(
    .F        (2),
    .K        (16),
    .ILAS_MF  (4),
    .SYNC_ERR (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sync_n      (sync_n),
    .cfg_data    (cfg_data),
    .lane_sel    (lane_sel),
    .ctrl_octets (ctrl_octets),
    .ctrl_k      (ctrl_k),
    .lmfc_cnt    (lmfc_cnt),
    .lmfc_tick   (lmfc_tick),
    .tx_ready    (tx_ready),
    .link_up     (link_up),
    .resync_cnt  (resync_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cgs(input string tag);
    chk({tag, "_lane"}, 32'(lane_sel), 32'd0);
    chk({tag, "_oct"}, 32'(ctrl_octets), 32'hBCBC);
    chk({tag, "_k"}, 32'(ctrl_k), 32'd3);
    chk({tag, "_txr"}, 32'(tx_ready), 32'd0);
    chk({tag, "_up"}, 32'(link_up), 32'd0);
  endtask

  task automatic wait_lane(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (lane_sel == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic resync_round(output bit ok);
    bit ok_a, ok_b;
    sync_n = 1'b1;
    wait_lane(2'd2, 120, ok_a);
    sync_n = 1'b0;
    wait_lane(2'd0, 10, ok_b);
    ok = ok_a && ok_b;
  endtask

  initial begin
    bit ok;
    reset  = 1'b0;
    sync_n = 1'b0;
    for (int n = 0; n < 14; n++) cfg_data[8*n +: 8] = 8'(n);

    repeat (3) @(negedge clock);
    chk_cgs("rst");
    chk("rst_tick", 32'(lmfc_tick), 32'd1);
    chk("rst_lmfc", 32'(lmfc_cnt), 32'd0);
    chk("rst_resync", 32'(resync_cnt), 32'd0);

    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      chk("lmfc_run", 32'(lmfc_cnt), 32'(n % 16));
    end
    @(negedge clock);
    chk("lmfc_5", 32'(lmfc_cnt), 32'd5);
    sync_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("cgs_hold_lmfc", 32'(lmfc_cnt), 32'd15);
    chk("cgs_hold_lane", 32'(lane_sel), 32'd0);

    @(negedge clock);
    chk("ilas_lane", 32'(lane_sel), 32'd1);
    chk("ilas_lmfc", 32'(lmfc_cnt), 32'd0);
    chk("ilas_tick", 32'(lmfc_tick), 32'd1);
    chk("ilas_f0_oct", 32'(ctrl_octets), 32'h011C);
    chk("ilas_f0_k", 32'(ctrl_k), 32'd1);
    repeat (15) @(negedge clock);
    chk("ilas_f15_oct", 32'(ctrl_octets), 32'h7C1E);
    chk("ilas_f15_k", 32'(ctrl_k), 32'd2);
    chk("ilas_f15_txr", 32'(tx_ready), 32'd0);
    @(negedge clock);
    chk("mf1_f0_oct", 32'(ctrl_octets), 32'h9C1C);
    chk("mf1_f0_k", 32'(ctrl_k), 32'd3);
    @(negedge clock);
    chk("mf1_f1_oct", 32'(ctrl_octets), 32'h0100);
    chk("mf1_f1_k", 32'(ctrl_k), 32'd0);
    repeat (6) @(negedge clock);
    chk("mf1_f7_oct", 32'(ctrl_octets), 32'h0D0C);
    chk("mf1_f7_k", 32'(ctrl_k), 32'd0);
    @(negedge clock);
    chk("mf1_f8_oct", 32'(ctrl_octets), 32'h1110);
    repeat (39) @(negedge clock);
    chk("last_lane", 32'(lane_sel), 32'd1);
    chk("last_txr", 32'(tx_ready), 32'd1);
    chk("last_up", 32'(link_up), 32'd0);
    @(negedge clock);
    chk("data_lane", 32'(lane_sel), 32'd2);
    chk("data_up", 32'(link_up), 32'd1);
    chk("data_txr", 32'(tx_ready), 32'd1);
    chk("data_oct", 32'(ctrl_octets), 32'd0);
    chk("data_k", 32'(ctrl_k), 32'd0);

    sync_n = 1'b0;
    repeat (3) @(negedge clock);
    sync_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("glitch3_up", 32'(link_up), 32'd1);
    chk("glitch3_resync", 32'(resync_cnt), 32'd0);

    sync_n = 1'b0;
    repeat (4) @(negedge clock);
    chk("err4_still_up", 32'(link_up), 32'd1);
    @(negedge clock);
    chk_cgs("err4");
    chk("err4_resync", 32'(resync_cnt), 32'd1);

    for (int r = 2; r <= 300; r++) begin
      resync_round(ok);
      if (!ok) begin
        chk("resync_round", 32'(ok), 32'd1);
        break;
      end
      if (r == 254) chk("resync_254", 32'(resync_cnt), 32'd254);
    end
    chk("resync_sat", 32'(resync_cnt), 32'd255);

    sync_n = 1'b1;
    wait_lane(2'd1, 40, ok);
    chk("abort_enter", 32'(ok), 32'd1);
    repeat (32) @(negedge clock);
    chk("abort_mf2_oct", 32'(ctrl_octets), 32'h011C);
    chk("abort_mf2_lmfc", 32'(lmfc_cnt), 32'd0);
    sync_n = 1'b0;
    @(negedge clock);
    chk("abort_lag_lane", 32'(lane_sel), 32'd1);
    @(negedge clock);
    chk_cgs("abort");
    chk("abort_resync", 32'(resync_cnt), 32'd255);

    sync_n = 1'b1;
    wait_lane(2'd2, 120, ok);
    chk("rst_data_enter", 32'(ok), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_cgs("rst_data");
    chk("rst_data_tick", 32'(lmfc_tick), 32'd1);
    chk("rst_data_lmfc", 32'(lmfc_cnt), 32'd0);
    chk("rst_data_resync", 32'(resync_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
